// File: rtl/surfctl_pkg.sv
// Shared types and constants for the SURF COUT receive path.
// Holds the training word default and nibble-rotation helpers.
package surfctl_pkg;

    localparam logic [31:0] DEFAULT_TRAIN_PATTERN = 32'hA55A6996;
    localparam int COUT_NIBBLES = 8;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } cout_state_t;

    function automatic logic [31:0] rotl_nibbles(
        input logic [31:0] w,
        input logic [2:0]  p
    );
        logic [63:0] d;
        d = {w, w} << {p, 2'b00};
        return d[63:32];
    endfunction

    function automatic logic rotations_distinct(input logic [31:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < COUT_NIBBLES; i++) begin
            for (int j = i + 1; j < COUT_NIBBLES; j++) begin
                if (rotl_nibbles(w, 3'(i)) == rotl_nibbles(w, 3'(j))) begin
                    ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/surfctl_rotation_match.sv
// Compares a 32-bit window against all nibble rotations of the
// training word; the lowest matching rotation index wins.
module surfctl_rotation_match
    import surfctl_pkg::*;
#(
    parameter logic [31:0] PATTERN = DEFAULT_TRAIN_PATTERN
) (
    input  logic [31:0] word,
    output logic        match,
    output logic [2:0]  p
);

    logic [COUT_NIBBLES-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < COUT_NIBBLES; i++) begin
            hit[i] = (word == rotl_nibbles(PATTERN, 3'(i)));
        end
    end

    // Walk downwards so the lowest index is the last one written.
    always_comb begin
        match = |hit;
        p     = 3'd0;
        for (int i = COUT_NIBBLES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                p = 3'(i);
            end
        end
    end

endmodule

// File: rtl/surfctl_cout_aligner.sv
// SYSCLK-side COUT receive stage: sliding window, capture,
// training-stream error check, lock tracking and phase report.
module surfctl_cout_aligner
    import surfctl_pkg::*;
#(
    parameter logic [31:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int          BLANK_CYCLES  = 12,
    parameter int          LOCK_CYCLES   = 1024
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic [3:0]  nibble_i,
    input  logic        iserdes_rst_i,
    input  logic        bitslip_i,
    input  logic        capture_i,
    output logic [31:0] data_o,
    output logic        biterr_o,
    output logic        locked_o,
    output logic [2:0]  phase_o,
    output logic        phase_valid_o
);

    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
    localparam logic [16:0] LOCK_TARGET = 17'(LOCK_CYCLES);

    if (BLANK_CYCLES < 8) begin : g_blank_min
        $error("BLANK_CYCLES must be at least 8");
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_lock_rng
        $error("LOCK_CYCLES must be within 1..65535");
    end
    if (!rotations_distinct(TRAIN_PATTERN)) begin : g_pat_chk
        $error("TRAIN_PATTERN rotations are not distinct");
    end

    cout_state_t   state;
    logic [BW-1:0] blank_cnt;
    logic [15:0]   clean_cnt;
    logic [31:0]   win;
    logic [31:0]   cand;
    logic [16:0]   clean_nxt;
    logic          err;
    logic          mask;
    logic          match;
    logic [2:0]    p;

    assign cand      = {win[27:0], nibble_i};
    assign err       = (nibble_i != win[31:28]);
    assign mask      = (state == BLANK) || iserdes_rst_i;
    assign clean_nxt = {1'b0, clean_cnt} + 17'd1;

    surfctl_rotation_match #(
        .PATTERN (TRAIN_PATTERN)
    ) u_match (
        .word  (cand),
        .match (match),
        .p     (p)
    );

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            win           <= '0;
            data_o        <= '0;
            biterr_o      <= 1'b0;
            locked_o      <= 1'b0;
            phase_o       <= 3'd0;
            phase_valid_o <= 1'b0;
            state         <= BLANK;
            blank_cnt     <= BLANK_LOAD;
            clean_cnt     <= '0;
        end else begin
            win      <= cand;
            biterr_o <= err && !mask;
            locked_o <= (state == LOCKED);
            if (capture_i) begin
                data_o <= cand;
            end
            if (match && !mask) begin
                phase_o       <= p;
                phase_valid_o <= 1'b1;
            end else begin
                phase_valid_o <= 1'b0;
            end
            if (iserdes_rst_i || bitslip_i) begin
                state     <= BLANK;
                blank_cnt <= BLANK_LOAD;
                clean_cnt <= '0;
            end else begin
                unique case (state)
                    BLANK: begin
                        if (blank_cnt <= BW'(1)) begin
                            state     <= CHECK;
                            blank_cnt <= '0;
                            clean_cnt <= '0;
                        end else begin
                            blank_cnt <= blank_cnt - BW'(1);
                        end
                    end
                    CHECK: begin
                        if (err) begin
                            clean_cnt <= '0;
                        end else if (clean_nxt >= LOCK_TARGET) begin
                            clean_cnt <= LOCK_TARGET[15:0];
                            state     <= LOCKED;
                        end else begin
                            clean_cnt <= clean_nxt[15:0];
                        end
                    end
                    LOCKED: begin
                        if (err) begin
                            state     <= CHECK;
                            clean_cnt <= '0;
                        end
                    end
                    default: begin
                        state     <= BLANK;
                        blank_cnt <= BLANK_LOAD;
                        clean_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_surfctl_cout_aligner.sv
// Directed bench for surfctl_cout_aligner with a capture scoreboard
// and an index-based model of the training stream phase.
module tb_surfctl_cout_aligner;

    localparam logic [31:0] PAT = 32'hA55A6996;
    localparam int B = 12;
    localparam int L = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  nib = 4'd0;
    logic        irst = 1'b0;
    logic        slip = 1'b0;
    logic        cap = 1'b0;
    logic [31:0] data;
    logic        biterr;
    logic        locked;
    logic [2:0]  ph;
    logic        pv;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int off = 0;
    int run = 0;
    int idx_last = 0;
    logic [31:0] bw = '0;
    logic [3:0]  xm = 4'd0;
    logic        rnd = 1'b0;
    logic        force_en = 1'b0;
    logic [3:0]  force_n = 4'd0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    surfctl_cout_aligner #(
        .TRAIN_PATTERN (PAT),
        .BLANK_CYCLES  (B),
        .LOCK_CYCLES   (L)
    ) dut (
        .sysclk_i      (clk),
        .sysclk_rst_i  (rst),
        .nibble_i      (nib),
        .iserdes_rst_i (irst),
        .bitslip_i     (slip),
        .capture_i     (cap),
        .data_o        (data),
        .biterr_o      (biterr),
        .locked_o      (locked),
        .phase_o       (ph),
        .phase_valid_o (pv)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pn(input int i);
        logic [31:0] t;
        t = PAT >> (28 - 4 * i);
        return t[3:0];
    endfunction

    // Drive one nibble, clock it in, sample #1 after the edge.
    task automatic feed();
        logic [3:0] n;
        logic       capd;
        if (rnd) begin
            n = 4'($urandom_range(0, 15));
        end else if (force_en) begin
            n = force_n;
        end else begin
            idx_last = (k + off) % 8;
            n = pn(idx_last) ^ xm;
        end
        if (rnd || force_en || xm != 4'd0) run = 0;
        else run++;
        nib  = n;
        capd = cap;
        if (cap) sb.push_back({bw[27:0], n});
        bw = {bw[27:0], n};
        k++;
        @(posedge clk);
        #1;
        if (capd) chk("capture_sb", data, sb.pop_front());
        cap = 1'b0;
        slip = 1'b0;
        xm = 4'd0;
        force_en = 1'b0;
        if (rst) bw = '0;
    endtask

    task automatic chk_phase(input string tag);
        chk({tag, "_pv"}, 32'(pv), 32'd1);
        chk({tag, "_ph"}, 32'(ph), 32'((idx_last + 1) % 8));
    endtask

    initial begin
        int nerr;
        int npv;
        int nbad;
        int slot;
        int ph_hold;
        logic [31:0] cap_exp;

        repeat (3) feed();
        chk("rst_data", data, 32'd0);
        chk("rst_biterr", 32'(biterr), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_phase", 32'(ph), 32'd0);
        chk("rst_pv", 32'(pv), 32'd0);

        // Test 1: clean stream, lock timing from reset release.
        rst = 1'b0;
        k = 0;
        run = 0;
        bw = '0;
        nerr = 0;
        npv = 0;
        nbad = 0;
        for (int n = 1; n <= B + L; n++) begin
            feed();
            if (biterr) nerr++;
            if (locked) nbad++;
            if (n <= B && pv) npv++;
            if (n > B) chk_phase("t1");
        end
        chk("t1_biterr_cnt", 32'(nerr), 32'd0);
        chk("t1_locked_early", 32'(nbad), 32'd0);
        chk("t1_pv_blank", 32'(npv), 32'd0);
        feed();
        chk("t1_locked", 32'(locked), 32'd1);

        // Test 2: single flipped nibble 6->7.
        for (int i = 0; i < 8 && ((k + off) % 8) != 4; i++) feed();
        ph_hold = int'(ph);
        xm = 4'd1;
        feed();
        chk("t2_err_first", 32'(biterr), 32'd1);
        chk("t2_locked_hold", 32'(locked), 32'd1);
        chk("t2_pv_nomatch", 32'(pv), 32'd0);
        chk("t2_ph_hold", 32'(ph), 32'(ph_hold));
        feed();
        chk("t2_locked_fall", 32'(locked), 32'd0);
        chk("t2_err_gap", 32'(biterr), 32'd0);
        nerr = 0;
        npv = 0;
        repeat (6) begin
            feed();
            if (biterr) nerr++;
            if (pv) npv++;
        end
        chk("t2_err_gap_cnt", 32'(nerr), 32'd0);
        chk("t2_pv_gap_cnt", 32'(npv), 32'd0);
        feed();
        chk("t2_err_second", 32'(biterr), 32'd1);
        chk_phase("t2");
        feed();
        chk("t2_err_after", 32'(biterr), 32'd0);

        // Test 3: slip into the rotation-3 stream, capture at alignment.
        slip = 1'b1;
        feed();
        chk_phase("t3_slip");
        ph_hold = (idx_last + 1) % 8;
        off += 3;
        run = 0;
        nerr = 0;
        npv = 0;
        nbad = 0;
        repeat (B) begin
            feed();
            if (biterr) nerr++;
            if (pv) npv++;
            if (int'(ph) != ph_hold) nbad++;
        end
        chk("t3_blank_err", 32'(nerr), 32'd0);
        chk("t3_blank_pv", 32'(npv), 32'd0);
        chk("t3_blank_ph", 32'(nbad), 32'd0);
        for (int i = 0; i < 8 && ((k + off) % 8) != 2; i++) feed();
        cap = 1'b1;
        feed();
        slot = (k - 1) % 8;
        chk("t3_data", data, 32'hA6996A55);
        chk("t3_phase", 32'(ph), 32'd3);
        chk("t3_pv", 32'(pv), 32'd1);
        repeat (3) feed();
        chk("t3_data_hold", data, 32'hA6996A55);
        for (int i = 0; i < 2000 && !locked; i++) feed();
        chk("t3_relock", 32'(locked), 32'd1);

        // Test 4: bitslip while locked, 1-nibble shift.
        slip = 1'b1;
        feed();
        chk("t4_locked_edge", 32'(locked), 32'd1);
        chk_phase("t4_slip");
        ph_hold = (idx_last + 1) % 8;
        off += 1;
        run = 0;
        nerr = 0;
        npv = 0;
        nbad = 0;
        for (int n = 1; n <= B; n++) begin
            feed();
            if (n == 1) chk("t4_locked_fall", 32'(locked), 32'd0);
            if (biterr) nerr++;
            if (pv) npv++;
            if (int'(ph) != ph_hold) nbad++;
        end
        chk("t4_blank_err", 32'(nerr), 32'd0);
        chk("t4_blank_pv", 32'(npv), 32'd0);
        chk("t4_blank_ph", 32'(nbad), 32'd0);
        for (int i = 0; i < 8; i++) begin
            feed();
            if (((k - 1) % 8) == slot) break;
        end
        chk("t4_phase", 32'(ph), 32'd4);
        chk("t4_pv", 32'(pv), 32'd1);

        // Test 5: ISERDES reset with random data, blank after release.
        irst = 1'b1;
        rnd = 1'b1;
        nerr = 0;
        npv = 0;
        repeat (20) begin
            feed();
            if (biterr) nerr++;
            if (pv) npv++;
        end
        chk("t5_rst_err", 32'(nerr), 32'd0);
        chk("t5_rst_pv", 32'(npv), 32'd0);
        chk("t5_rst_locked", 32'(locked), 32'd0);
        irst = 1'b0;
        nerr = 0;
        npv = 0;
        repeat (B - 1) begin
            feed();
            if (biterr) nerr++;
            if (pv) npv++;
        end
        chk("t5_rel_err", 32'(nerr), 32'd0);
        chk("t5_rel_pv", 32'(npv), 32'd0);
        rnd = 1'b0;
        force_en = 1'b1;
        force_n = bw[31:28] ^ 4'h1;
        feed();
        chk("t5_blank_last", 32'(biterr), 32'd0);
        force_en = 1'b1;
        force_n = bw[31:28] ^ 4'h1;
        feed();
        chk("t5_check_first", 32'(biterr), 32'd1);

        // Test 6: capture with bitslip, capture in BLANK, reset.
        repeat (10) feed();
        cap = 1'b1;
        slip = 1'b1;
        feed();
        cap_exp = bw;
        off += 1;
        run = 0;
        repeat (3) feed();
        chk("t6_data_hold", data, cap_exp);
        cap = 1'b1;
        feed();
        repeat (15) feed();
        chk_phase("t6_pre_rst");
        xm = 4'd1;
        feed();
        chk("t6_err_pre_rst", 32'(biterr), 32'd1);
        rst = 1'b1;
        feed();
        chk("t6_rst_data", data, 32'd0);
        chk("t6_rst_biterr", 32'(biterr), 32'd0);
        chk("t6_rst_locked", 32'(locked), 32'd0);
        chk("t6_rst_phase", 32'(ph), 32'd0);
        chk("t6_rst_pv", 32'(pv), 32'd0);
        rst = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
